// File: rtl/enemy_director_if.sv
// enemy_director_if
//   Bundles the game-rule controller's object-side signals.
//   master : the side that supplies positions, start and frame_tick and
//            consumes the strobes (top level / bench).
//   slave  : the enemy_director itself.
//   Inputs to the director : start, frame_tick, enemy/ebullet/player/pbullet
//                            x,y (10 bit each), pbullet_active.
//   Outputs of the director: move_down, move_bullet, shoot, killed,
//                            bullet_hit, pbullet_hit, stop, score[15:0],
//                            lives[1:0].
interface enemy_director_if;
  logic        start;
  logic        frame_tick;
  logic [9:0]  enemy_x;
  logic [9:0]  enemy_y;
  logic [9:0]  ebullet_x;
  logic [9:0]  ebullet_y;
  logic [9:0]  player_x;
  logic [9:0]  player_y;
  logic [9:0]  pbullet_x;
  logic [9:0]  pbullet_y;
  logic        pbullet_active;
  logic        move_down;
  logic        move_bullet;
  logic        shoot;
  logic        killed;
  logic        bullet_hit;
  logic        pbullet_hit;
  logic        stop;
  logic [15:0] score;
  logic [1:0]  lives;

  modport master (
    output start, frame_tick, enemy_x, enemy_y, ebullet_x, ebullet_y,
           player_x, player_y, pbullet_x, pbullet_y, pbullet_active,
    input  move_down, move_bullet, shoot, killed, bullet_hit, pbullet_hit,
           stop, score, lives
  );

  modport slave (
    input  start, frame_tick, enemy_x, enemy_y, ebullet_x, ebullet_y,
           player_x, player_y, pbullet_x, pbullet_y, pbullet_active,
    output move_down, move_bullet, shoot, killed, bullet_hit, pbullet_hit,
           stop, score, lives
  );
endinterface

// File: rtl/enemy_director.sv
// enemy_director
//   Game-rule controller: paces the enemy (move_down, move_bullet, shoot),
//   resolves collisions once per frame, and keeps score and lives.
//   Ports:
//     clk    : clock
//     reset  : asynchronous, active-high; returns to IDLE with stop=1
//     bus    : enemy_director_if.slave (positions in, strobes/score/lives out)
//   Optional feature: define DIRECTOR_LFSR_SHOOT_EN to gate each shoot
//   opportunity with bit 0 of an 8-bit LFSR (taps 8,6,5,4, seed 8'hA5).
//   All outputs are registered.
module enemy_director #(
  parameter int MOVE_DIV   = 400000,
  parameter int BULLET_DIV = 100000,
  parameter int SHOOT_DIV  = 25000000,
  parameter int BOX_WIDTH  = 32,
  parameter int BOX_HEIGHT = 32,
  parameter int BULLET_H   = 7,
  parameter int MAX_Y      = 480,
  parameter int LIVES      = 3
) (
  input  logic             clk,
  input  logic             reset,
  enemy_director_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_EKILL = 3'd2;
  localparam logic [2:0] S_PHIT  = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam int MW = $clog2(MOVE_DIV + 1);
  localparam int BW = $clog2(BULLET_DIV + 1);
  localparam int SW = $clog2(SHOOT_DIV + 1);

  localparam logic [10:0] BOX_W11 = 11'(BOX_WIDTH);
  localparam logic [10:0] BOX_H11 = 11'(BOX_HEIGHT);
  localparam logic [10:0] BUL_H11 = 11'(BULLET_H);
  localparam logic [10:0] MAX_Y11 = 11'(MAX_Y);

  // Axis-aligned box overlap; sums kept in 11 bits so edges near 1023 cannot wrap.
  function automatic logic overlap(
    input logic [9:0]  ax, input logic [9:0]  ay,
    input logic [10:0] aw, input logic [10:0] ah,
    input logic [9:0]  bx, input logic [9:0]  by,
    input logic [10:0] bw, input logic [10:0] bh
  );
    return ({1'b0, ax} < ({1'b0, bx} + bw)) && ({1'b0, bx} < ({1'b0, ax} + aw)) &&
           ({1'b0, ay} < ({1'b0, by} + bh)) && ({1'b0, by} < ({1'b0, ay} + ah));
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [2:0]    state;
  logic [2:0]    nxt;
  logic          kp, hp, hb;          // hb: pending hit came from enemy body
  logic          kp_n, hp_n, hb_n;
  logic          kill_det, hit_det, body_det;
  logic          advance;
  logic          md_tick, mb_tick, sh_tick, shoot_n;
  logic [MW-1:0] md_cnt;
  logic [BW-1:0] mb_cnt;
  logic [SW-1:0] sh_cnt;
  logic          idle_like;

  assign idle_like = (state == S_IDLE) || (state == S_OVER);

  always_comb begin
    kill_det = bus.pbullet_active &&
               overlap(bus.pbullet_x, bus.pbullet_y, BOX_W11, BUL_H11,
                       bus.enemy_x, bus.enemy_y, BOX_W11, BOX_H11);
    body_det = overlap(bus.enemy_x, bus.enemy_y, BOX_W11, BOX_H11,
                       bus.player_x, bus.player_y, BOX_W11, BOX_H11);
    hit_det  = (({1'b0, bus.ebullet_y} < MAX_Y11) &&
                overlap(bus.ebullet_x, bus.ebullet_y, BOX_W11, BUL_H11,
                        bus.player_x, bus.player_y, BOX_W11, BOX_H11)) || body_det;
  end

  // Pending flags include this cycle's detection so the strobe lands one cycle after frame_tick.
  always_comb begin
    kp_n = kp;
    hp_n = hp;
    hb_n = hb;
    if (state == S_RUN && bus.frame_tick) begin
      kp_n = kp | kill_det;
      hp_n = hp | hit_det;
      hb_n = hb | body_det;
    end
    nxt = state;
    case (state)
      S_IDLE, S_OVER: if (bus.start) nxt = S_RUN;
      S_RUN: begin
        if (kp_n)      nxt = S_EKILL;
        else if (hp_n) nxt = S_PHIT;
      end
      S_EKILL: nxt = hp ? S_PHIT : S_RUN;
      S_PHIT:  nxt = (bus.lives <= 2'd1) ? S_OVER : S_RUN;
      default: nxt = S_IDLE;
    endcase
  end

  // Dividers only count while staying in RUN, so a pulse is never swallowed by EKILL/PHIT.
  assign advance = (state == S_RUN) && (nxt == S_RUN);
  assign md_tick = advance && (md_cnt == MW'(MOVE_DIV - 1));
  assign mb_tick = advance && (mb_cnt == BW'(BULLET_DIV - 1));
  assign sh_tick = advance && (sh_cnt == SW'(SHOOT_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= '0;
      mb_cnt <= '0;
      sh_cnt <= '0;
    end else if (idle_like) begin
      md_cnt <= '0;
      mb_cnt <= '0;
      sh_cnt <= '0;
    end else if (advance) begin
      md_cnt <= md_tick ? '0 : md_cnt + MW'(1);
      mb_cnt <= mb_tick ? '0 : mb_cnt + BW'(1);
      sh_cnt <= sh_tick ? '0 : sh_cnt + SW'(1);
    end
  end

`ifdef DIRECTOR_LFSR_SHOOT_EN
  logic [7:0] lfsr;
  logic       lfsr_fb;

  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  // New bit 0 equals the feedback bit, so the gate uses the post-advance value.
  assign shoot_n = sh_tick && lfsr_fb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        lfsr <= 8'hA5;
    else if (sh_tick) lfsr <= {lfsr[6:0], lfsr_fb};
  end
`else
  assign shoot_n = sh_tick;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      kp              <= 1'b0;
      hp              <= 1'b0;
      hb              <= 1'b0;
      bus.move_down   <= 1'b0;
      bus.move_bullet <= 1'b0;
      bus.shoot       <= 1'b0;
      bus.killed      <= 1'b0;
      bus.bullet_hit  <= 1'b0;
      bus.pbullet_hit <= 1'b0;
      bus.stop        <= 1'b1;
      bus.score       <= 16'd0;
      bus.lives       <= 2'(LIVES);
    end else begin
      state           <= nxt;
      kp              <= kp_n && (state != S_EKILL);
      hp              <= hp_n && (state != S_PHIT);
      hb              <= hb_n && (state != S_PHIT);
      bus.move_down   <= md_tick;
      bus.move_bullet <= mb_tick;
      bus.shoot       <= shoot_n;
      // Strobes are raised on entry so they coincide with the one-cycle EKILL/PHIT state.
      bus.killed      <= (nxt == S_EKILL) || ((nxt == S_PHIT) && hb_n);
      bus.pbullet_hit <= (nxt == S_EKILL);
      bus.bullet_hit  <= (nxt == S_PHIT);
      bus.stop        <= (nxt == S_IDLE) || (nxt == S_OVER);
      if (idle_like && bus.start) begin
        bus.score <= 16'd0;
        bus.lives <= 2'(LIVES);
      end else if (state == S_EKILL) begin
        bus.score <= sat_inc(bus.score);
      end else if (state == S_PHIT && bus.lives != 2'd0) begin
        bus.lives <= bus.lives - 2'd1;
      end
    end
  end

endmodule
